// File: rtl/mem_burst_responder.sv
// On-chip burst memory responder. Serves write/read bursts from a frame
// read/write block out of an internal word-addressed RAM, using the same
// data-request / data-valid / finish handshakes as the DDR controller UI.
module mem_burst_responder #(
  parameter int unsigned MEM_DATA_BITS  = 32,
  parameter int unsigned ADDR_BITS      = 28,
  parameter int unsigned BUSRT_BITS     = 10,
  parameter int unsigned MEM_DEPTH_BITS = 12
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     rd_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  input  logic                     wr_burst_req,
  input  logic [BUSRT_BITS-1:0]    wr_burst_len,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic                     wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  output logic                     wr_burst_finish,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_LAST, RD, RD_DRAIN, RD_DONE, GAP
  } state_t;

  localparam int unsigned DEPTH = 2 ** MEM_DEPTH_BITS;

  state_t                    state_q;
  logic                      last_wr_q;   // 1: last grant was a write
  logic [MEM_DEPTH_BITS-1:0] base_q;
  logic [BUSRT_BITS-1:0]     len_q;
  logic [BUSRT_BITS-1:0]     cnt_q;       // request / read-issue index
  logic [BUSRT_BITS-1:0]     wcnt_q;      // write capture index
  logic                      wreq_q;
  logic                      req_d_q;     // wreq_q delayed: capture qualifier
  logic                      wfin_q;
  logic                      rvld_q;
  logic                      rfin_q;
  logic [MEM_DATA_BITS-1:0]  rdata_q;
  logic [MEM_DATA_BITS-1:0]  mem_q [0:DEPTH-1];

  logic                      grant_wr;
  logic                      grant_rd;
  logic                      last_beat;
  logic [MEM_DEPTH_BITS-1:0] raddr;
  logic [MEM_DEPTH_BITS-1:0] waddr;

  // Only the low address bits select a RAM word; the rest are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_burst_addr[ADDR_BITS-1:MEM_DEPTH_BITS],
                              wr_burst_addr[ADDR_BITS-1:MEM_DEPTH_BITS]};

  // On a tie, alternate: grant the opposite of the last granted type.
  assign grant_wr  = wr_burst_req & (~rd_burst_req | ~last_wr_q);
  assign grant_rd  = rd_burst_req & (~wr_burst_req |  last_wr_q);
  assign last_beat = (cnt_q == len_q - BUSRT_BITS'(1));
  // Offsets wrap modulo the RAM depth.
  assign raddr     = base_q + MEM_DEPTH_BITS'(cnt_q);
  assign waddr     = base_q + MEM_DEPTH_BITS'(wcnt_q);

  // Burst FSM with registered handshake outputs and read data register.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      wreq_q    <= 1'b0;
      req_d_q   <= 1'b0;
      wfin_q    <= 1'b0;
      rvld_q    <= 1'b0;
      rfin_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      req_d_q <= wreq_q;
      rvld_q  <= (state_q == RD);
      wfin_q  <= 1'b0;
      rfin_q  <= 1'b0;
      if (state_q == RD) rdata_q <= mem_q[raddr];
      if (req_d_q)       wcnt_q  <= wcnt_q + BUSRT_BITS'(1);
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            last_wr_q <= 1'b1;
            base_q    <= wr_burst_addr[MEM_DEPTH_BITS-1:0];
            len_q     <= wr_burst_len;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            if (wr_burst_len == '0) begin
              wfin_q  <= 1'b1;
              state_q <= WR_LAST;
            end else begin
              wreq_q  <= 1'b1;
              state_q <= WR;
            end
          end else if (grant_rd) begin
            last_wr_q <= 1'b0;
            base_q    <= rd_burst_addr[MEM_DEPTH_BITS-1:0];
            len_q     <= rd_burst_len;
            cnt_q     <= '0;
            if (rd_burst_len == '0) begin
              rfin_q  <= 1'b1;
              state_q <= RD_DONE;
            end else begin
              state_q <= RD;
            end
          end
        end
        WR: begin
          if (last_beat) begin
            wreq_q  <= 1'b0;
            wfin_q  <= 1'b1;
            state_q <= WR_LAST;
          end else begin
            cnt_q <= cnt_q + BUSRT_BITS'(1);
          end
        end
        WR_LAST: state_q <= GAP;
        RD: begin
          if (last_beat) state_q <= RD_DRAIN;
          else           cnt_q   <= cnt_q + BUSRT_BITS'(1);
        end
        RD_DRAIN: begin
          rfin_q  <= 1'b1;
          state_q <= RD_DONE;
        end
        RD_DONE: state_q <= GAP;
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM write port: capture the word presented one cycle after its request.
  always_ff @(posedge mem_clk) begin
    if (!rst && req_d_q) mem_q[waddr] <= wr_burst_data;
  end

  assign wr_burst_data_req   = wreq_q;
  assign wr_burst_finish     = wfin_q;
  assign rd_burst_data_valid = rvld_q;
  assign rd_burst_finish     = rfin_q;
  assign rd_burst_data       = rdata_q;
  assign busy                = (state_q != IDLE);

endmodule
